uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_master` transmitter between up to `NREQ` byte requesters.
- Each requester presents a byte and a request.
- The arbiter picks a winner, latches its byte, drives `data`/`en_tx` into `uart_master`, and holds them until `u_tx_done`.
- It then acknowledges the winner and returns the line to idle before the next grant.
- It sits between the system bus clients and `uart_master`, on the same clock domain as `clk_tx`.

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that time-shares one uart_master transmitter between NREQ
// byte requesters: grant, hold data/en_tx until done (or timeout), ack, release.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*DATA_W-1:0] req_data_i,
    input  logic                   u_tx_done_i,
    output logic [NREQ-1:0]        grant_o,
    output logic [NREQ-1:0]        ack_o,
    output logic                   err_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   en_tx_o,
    output logic                   busy_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]   CNT_MAX = '1;
    localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t            state_q;
    logic [IW-1:0]     last_q, cur_q;
    logic [CW-1:0]     cnt_q;
    logic [NREQ-1:0]   grant_q, ack_q;
    logic              err_q, en_tx_q, busy_q;
    logic [DATA_W-1:0] data_q;

    logic          win_vld_d;
    logic [IW-1:0] win_idx_d;
    logic          to_hit;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_vld_d && req_i[(int'(last_q) + k) % NREQ]) begin
                win_vld_d = 1'b1;
                win_idx_d = IW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            cur_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            en_tx_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        data_q  <= req_data_i[win_idx_d*DATA_W +: DATA_W];
                        cur_q   <= win_idx_d;
                        last_q  <= win_idx_d;
                        grant_q <= ONE_HOT << win_idx_d;
                        en_tx_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (cnt_q != CNT_MAX)
                        cnt_q <= cnt_q + 1'b1;
                    // Done takes priority over a coincident timeout.
                    if (u_tx_done_i) begin
                        en_tx_q <= 1'b0;
                        ack_q   <= ONE_HOT << cur_q;
                        state_q <= RELEASE;
                    end else if (to_hit) begin
                        en_tx_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!u_tx_done_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    en_tx_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign data_o  = data_q;
    assign en_tx_o = en_tx_q;
    assign busy_o  = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed phases push expected grant/ack
// events; a negedge monitor pops and compares as the DUT emits them.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam logic [1:0] K_G = 2'd0, K_A = 2'd1, K_E = 2'd2;

    typedef struct {
        logic [1:0]      kind;
        logic [NREQ-1:0] vec;
        logic [DW-1:0]   data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic               u_tx_done = 1'b0;
    logic [NREQ-1:0]    grant, ack;
    logic               err, en_tx, busy;
    logic [DW-1:0]      data;

    logic [NREQ-1:0]    req_t = '0;
    logic [NREQ*DW-1:0] req_data_t = '0;
    logic               done_t = 1'b0;
    logic [NREQ-1:0]    grant_t, ack_t;
    logic               err_t, en_tx_t, busy_t;
    logic [DW-1:0]      data_t;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    int  model_en = 0;
    int  done_dly = 20;
    int  done_hold = 1;
    int  mcnt = 0;
    int  hold = 0;

    logic [DW-1:0] hold_data;
    logic          in_send = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(65535)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
        .u_tx_done_i(u_tx_done), .grant_o(grant), .ack_o(ack), .err_o(err),
        .data_o(data), .en_tx_o(en_tx), .busy_o(busy));

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(16)) dut_to (
        .clk_i(clk), .rst_i(rst), .req_i(req_t), .req_data_i(req_data_t),
        .u_tx_done_i(done_t), .grant_o(grant_t), .ack_o(ack_t), .err_o(err_t),
        .data_o(data_t), .en_tx_o(en_tx_t), .busy_o(busy_t));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input int idx, input logic [DW-1:0] d);
        ev_t e;
        e.kind = kind;
        e.vec  = NREQ'(1) << idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_q(input int n, input int budget, input string name);
        int k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() > n) chk(name, exp_q.size(), n);
    endtask

    // uart_master stand-in: done rises done_dly cycles into en_tx, held done_hold cycles.
    always @(negedge clk) begin
        if (model_en == 0) begin
            u_tx_done = 1'b0; mcnt = 0; hold = 0;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) u_tx_done = 1'b0;
        end else if (en_tx && !u_tx_done) begin
            mcnt++;
            if (mcnt >= done_dly) begin
                u_tx_done = 1'b1; hold = done_hold; mcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            in_send = 1'b0;
        end else begin
            if (in_send && en_tx && grant == '0) begin
                checks++;
                if (data !== hold_data) begin
                    errors++;
                    $display("FAIL data_hold got=%0h exp=%0h", data, hold_data);
                end
            end
            if (grant != '0 || ack != '0 || err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out grant=%b ack=%b err=%b", grant, ack, err);
                end else begin
                    ev_t e;
                    logic [1:0]      gk;
                    logic [NREQ-1:0] gv;
                    e  = exp_q.pop_front();
                    gk = (grant != '0) ? K_G : (ack != '0) ? K_A : K_E;
                    gv = (grant != '0) ? grant : ack;
                    if (gk !== e.kind || (gk != K_E && gv !== e.vec) ||
                        (gk == K_G && (data !== e.data || en_tx !== 1'b1)) ||
                        (gk == K_A && en_tx !== 1'b0)) begin
                        errors++;
                        $display("FAIL event got kind=%0d vec=%b data=%h en_tx=%b exp kind=%0d vec=%b data=%h",
                                 gk, gv, data, en_tx, e.kind, e.vec, e.data);
                    end
                    if (gk == K_G) begin hold_data = data; in_send = 1'b1; end
                    else in_send = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, got;
        logic saw_ack;

        // Reset with every requester asking.
        req = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #2 rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0); chk("rst_ack", ack, 0); chk("rst_err", err, 0);
        chk("rst_en_tx", en_tx, 0); chk("rst_busy", busy, 0); chk("rst_data", data, 0);
        repeat (2) @(negedge clk);
        push(K_G, 0, 8'hA0);
        model_en = 1;
        rst = 1'b0;
        wait_q(0, 50, "first_grant_timeout");

        // Reset mid-SEND: en_tx must drop before the next edge, no ack follows.
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_en_tx", en_tx, 0); chk("midrst_busy", busy, 0);
        chk("midrst_grant", grant, 0); chk("midrst_ack", ack, 0);
        model_en = 0;
        repeat (2) @(negedge clk);

        // Round robin over all four, pointer restarts at requester 0.
        for (int i = 0; i < 4; i++) begin
            push(K_G, i, 8'hA0 + 8'(i)); push(K_A, i, 8'h00);
        end
        push(K_G, 0, 8'hA0); push(K_A, 0, 8'h00);
        model_en = 1;
        rst = 1'b0;
        wait_q(1, 1000, "rr_timeout");
        req = '0;
        wait_q(0, 100, "rr_ack_timeout");
        repeat (3) @(posedge clk); #1;
        chk("rr_idle_busy", busy, 0);

        // Single requester 2; dropping req during SEND still completes.
        req_data = {8'h33, 8'h95, 8'h11, 8'h00};
        push(K_G, 2, 8'h95); push(K_A, 2, 8'h00);
        req = 4'b0100;
        wait_q(1, 100, "single_grant_timeout");
        req = '0;
        req_data = '0;
        wait_q(0, 100, "single_ack_timeout");

        // Fairness skip: last winner was 2, so 3 goes first, then 0, alternating.
        req_data = {8'hC3, 8'hEE, 8'hEE, 8'hC0};
        push(K_G, 3, 8'hC3); push(K_A, 3, 8'h00); push(K_G, 0, 8'hC0); push(K_A, 0, 8'h00);
        push(K_G, 3, 8'hC3); push(K_A, 3, 8'h00); push(K_G, 0, 8'hC0); push(K_A, 0, 8'h00);
        req = 4'b1001;
        wait_q(1, 1000, "fair_timeout");
        req = '0;
        wait_q(0, 100, "fair_ack_timeout");

        // Sticky done: no new grant while done stays high in RELEASE.
        req_data = {8'h00, 8'h00, 8'hD1, 8'h00};
        done_hold = 10;
        push(K_G, 1, 8'hD1); push(K_A, 1, 8'h00); push(K_G, 1, 8'hD1); push(K_A, 1, 8'h00);
        req = 4'b0010;
        wait_q(3, 100, "sticky_grant_timeout");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (u_tx_done) begin
                n++;
                chk("sticky_busy", busy, 1);
                chk("sticky_no_grant", grant, 0);
            end else if (n > 0) begin
                break;
            end
        end
        done_hold = 1;
        wait_q(1, 200, "sticky_regrant_timeout");
        req = '0;
        wait_q(0, 100, "sticky_ack_timeout");

        // Timeout instance: done never arrives.
        req_data_t = {8'h00, 8'h00, 8'hE1, 8'hE0};
        req_t = 4'b0011;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (grant_t != '0) break;
        end
        chk("to_grant0", grant_t, 4'b0001);
        chk("to_data0", data_t, 8'hE0);
        got = -1;
        saw_ack = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ack_t != '0) saw_ack = 1'b1;
            if (err_t) begin got = k; break; end
        end
        chk("to_err_cycle", got, 16);
        chk("to_en_tx", en_tx_t, 0);
        chk("to_no_ack", saw_ack, 0);
        @(posedge clk); #1;
        chk("to_idle_busy", busy_t, 0);
        chk("to_err_pulse", err_t, 0);
        @(posedge clk); #1;
        chk("to_next_grant", grant_t, 4'b0010);
        chk("to_next_data", data_t, 8'hE1);
        req_t = '0;

        repeat (5) @(posedge clk); #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
